// File: rtl/cp0_regs.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause and EPC, with exception/ERET commit.
// Optional timer (Count/Compare/timer interrupt) is enabled by defining CP0_TIMER_EN.
module cp0_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic [5:0]  int_i,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o,
  output logic        int_pending_o
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  // BEV is hard-wired to 1; only IM, EXL and IE hold state.
  function automatic logic [31:0] status_pack(input logic [7:0] im, input logic exl, input logic ie);
    status_pack = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  endfunction

  function automatic logic [31:0] cause_pack(input logic bd, input logic [7:0] ip, input logic [4:0] code);
    cause_pack = {bd, 15'd0, ip, 1'b0, code, 2'b00};
  endfunction

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;

  logic        w_timer;
  logic        w_byp;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic        w_addr_exc;

  assign w_wr_status = we && (waddr == A_STATUS);
  assign w_wr_cause  = we && (waddr == A_CAUSE);
  assign w_wr_epc    = we && (waddr == A_EPC);
  assign w_byp       = we && (waddr == raddr);
  assign w_addr_exc  = (exc_code == 5'd4) || (exc_code == 5'd5);

  assign w_ip     = {r_ip_hw[5] | w_timer, r_ip_hw[4:0], r_ip_sw};
  assign w_status = status_pack(r_im, r_exl, r_ie);
  assign w_cause  = cause_pack(r_bd, w_ip, r_exccode);

  assign status_o      = w_status;
  assign cause_o       = w_cause;
  assign epc_o         = r_epc;
  assign int_pending_o = r_ie & ~r_exl & (|(w_ip & r_im));

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tick;
  logic        r_timer;
  logic        w_wr_count;
  logic        w_wr_compare;

  assign w_wr_count   = we && (waddr == A_COUNT);
  assign w_wr_compare = we && (waddr == A_COMPARE);
  assign w_timer      = r_timer;
  assign timer_int_o  = r_timer;

  // Count advances on every other edge; software writes override the increment and restart the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_tick    <= 1'b0;
      r_timer   <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= wdata;
        r_tick  <= 1'b0;
      end else begin
        r_tick <= ~r_tick;
        if (r_tick) begin
          r_count <= r_count + 32'd1;
        end
      end
      if (w_wr_compare) begin
        r_compare <= wdata;
        r_timer   <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_timer <= 1'b1;
      end
    end
  end
`else
  assign w_timer     = 1'b0;
  assign timer_int_o = 1'b0;
`endif

  // Read port: a same-cycle write is forwarded, filtered through the writable-field masks.
  always_comb begin
    rdata = 32'd0;
    case (raddr)
      A_BADVADDR: rdata = r_badvaddr;
      A_STATUS:   rdata = w_byp ? status_pack(wdata[15:8], wdata[1], wdata[0]) : w_status;
      A_CAUSE:    rdata = w_byp ? cause_pack(r_bd, {w_ip[7:2], wdata[9:8]}, r_exccode) : w_cause;
      A_EPC:      rdata = w_byp ? wdata : r_epc;
`ifdef CP0_TIMER_EN
      A_COUNT:    rdata = w_byp ? wdata : r_count;
      A_COMPARE:  rdata = w_byp ? wdata : r_compare;
`endif
      default:    rdata = 32'd0;
    endcase
  end

  // Exception beats ERET beats software write on EXL/EPC; IM, IE and soft IP always take the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_im       <= 8'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ip_hw    <= 6'd0;
      r_ip_sw    <= 2'd0;
      r_exccode  <= 5'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      r_ip_hw <= int_i;
      if (w_wr_status) begin
        r_im <= wdata[15:8];
        r_ie <= wdata[0];
      end
      if (w_wr_cause) begin
        r_ip_sw <= wdata[9:8];
      end
      if (exc_valid) begin
        r_exccode <= exc_code;
        r_exl     <= 1'b1;
        if (w_addr_exc) begin
          r_badvaddr <= exc_badvaddr;
        end
        if (!r_exl) begin
          r_epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          r_bd  <= exc_bd;
        end
      end else begin
        if (w_wr_epc) begin
          r_epc <= wdata;
        end
        if (eret) begin
          r_exl <= 1'b0;
        end else if (w_wr_status) begin
          r_exl <= wdata[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed, table-driven bench for cp0_regs; timer expectations follow CP0_TIMER_EN.
module tb_cp0_regs;

`ifdef CP0_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  int_i;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;
  logic        int_pending_o;

  always #5 clk = ~clk;

  cp0_regs dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .int_i(int_i),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr), .eret(eret),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int_o(timer_int_o), .int_pending_o(int_pending_o)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  int_i;
    logic [31:0] exp_rdata;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[24];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra, input logic [5:0] ii,
                              input logic [31:0] er, input logic ep);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.int_i = ii;
    v.exp_rdata = er; v.exp_pend = ep;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; exc_valid = 1'b0; eret = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd, input logic [31:0] bva);
    exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
    cycle();
    exc_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr = 5'd0; int_i = 6'd0;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0; exc_badvaddr = 32'd0;
    eret = 1'b0;

    vecs[0]  = mk(1'b0, 5'd0,  32'h0,        5'd12, 6'd0,     32'h0040_0000, 1'b0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0,        5'd13, 6'd0,     32'h0000_0000, 1'b0);
    vecs[2]  = mk(1'b0, 5'd0,  32'h0,        5'd14, 6'd0,     32'h0000_0000, 1'b0);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0,        5'd7,  6'd0,     32'h0000_0000, 1'b0);
    vecs[4]  = mk(1'b1, 5'd12, 32'hFFFF_FFFF, 5'd12, 6'd0,    32'h0040_FF03, 1'b0);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0,        5'd12, 6'd0,     32'h0040_FF03, 1'b0);
    vecs[6]  = mk(1'b1, 5'd12, 32'h0000_FF01, 5'd13, 6'd0,    32'h0000_0000, 1'b0);
    vecs[7]  = mk(1'b1, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'd0,    32'h0000_0300, 1'b0);
    vecs[8]  = mk(1'b0, 5'd0,  32'h0,        5'd13, 6'd0,     32'h0000_0300, 1'b1);
    vecs[9]  = mk(1'b1, 5'd13, 32'h0,        5'd12, 6'd0,     32'h0040_FF01, 1'b1);
    vecs[10] = mk(1'b0, 5'd0,  32'h0,        5'd13, 6'b000001, 32'h0000_0000, 1'b0);
    vecs[11] = mk(1'b0, 5'd0,  32'h0,        5'd13, 6'd0,     32'h0000_0400, 1'b1);
    vecs[12] = mk(1'b0, 5'd0,  32'h0,        5'd13, 6'b100000, 32'h0000_0000, 1'b0);
    vecs[13] = mk(1'b0, 5'd0,  32'h0,        5'd13, 6'd0,     32'h0000_8000, 1'b1);
    vecs[14] = mk(1'b1, 5'd14, 32'h1234_5678, 5'd14, 6'd0,    32'h1234_5678, 1'b0);
    vecs[15] = mk(1'b0, 5'd0,  32'h0,        5'd14, 6'd0,     32'h1234_5678, 1'b0);
    vecs[16] = mk(1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  6'd0,    32'h0000_0000, 1'b0);
    vecs[17] = mk(1'b0, 5'd0,  32'h0,        5'd8,  6'd0,     32'h0000_0000, 1'b0);
    vecs[18] = mk(1'b1, 5'd20, 32'hFFFF_FFFF, 5'd20, 6'd0,    32'h0000_0000, 1'b0);
    vecs[19] = mk(1'b1, 5'd12, 32'h0,        5'd12, 6'd0,     32'h0040_0000, 1'b0);
    vecs[20] = mk(1'b1, 5'd9,  32'h55,       5'd9,  6'd0,     TIMER_ON ? 32'h55 : 32'h0, 1'b0);
    vecs[21] = mk(1'b0, 5'd0,  32'h0,        5'd9,  6'd0,     TIMER_ON ? 32'h55 : 32'h0, 1'b0);
    vecs[22] = mk(1'b1, 5'd11, 32'h77,       5'd11, 6'd0,     TIMER_ON ? 32'h77 : 32'h0, 1'b0);
    vecs[23] = mk(1'b0, 5'd0,  32'h0,        5'd11, 6'd0,     TIMER_ON ? 32'h77 : 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check32("rst_status", status_o, 32'h0040_0000);
    check32("rst_cause", cause_o, 32'h0);
    check32("rst_epc", epc_o, 32'h0);
    check32("rst_timer", {31'd0, timer_int_o}, 32'h0);
    check32("rst_pending", {31'd0, int_pending_o}, 32'h0);
    cycle();

    for (int i = 0; i < 24; i++) begin
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr = vecs[i].raddr; int_i = vecs[i].int_i;
      #1;
      check32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check32($sformatf("vec%0d_pend", i), {31'd0, int_pending_o}, {31'd0, vecs[i].exp_pend});
      cycle();
    end
    idle();
    int_i = 6'd0;

    // Timer: IM7 + IE, Compare=10, Count=0; flag rises the edge after Count reaches 10.
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd0);
    repeat (20) cycle();
    check32("timer_early", {31'd0, timer_int_o}, 32'h0);
    cycle();
    check32("timer_set", {31'd0, timer_int_o}, {31'd0, TIMER_ON});
    check32("timer_pend", {31'd0, int_pending_o}, {31'd0, TIMER_ON});
    wr(5'd11, 32'd0);
    check32("timer_clr", {31'd0, timer_int_o}, 32'h0);
    check32("timer_clr_pend", {31'd0, int_pending_o}, 32'h0);

`ifdef CP0_TIMER_EN
    wr(5'd9, 32'hFFFF_FFFF);
    raddr = 5'd9;
    cycle();
    check32("count_hold", rdata, 32'hFFFF_FFFF);
    cycle();
    check32("count_wrap", rdata, 32'h0);
`endif

    exc(5'd4, 32'h8000_1004, 1'b1, 32'h13);
    raddr = 5'd8;
    #1;
    check32("exc1_epc", epc_o, 32'h8000_1000);
    check32("exc1_cause", cause_o, 32'h8000_0010);
    check32("exc1_status", status_o, 32'h0040_8003);
    check32("exc1_badvaddr", rdata, 32'h13);

    exc(5'd8, 32'h0000_1234, 1'b0, 32'h99);
    check32("exc2_epc", epc_o, 32'h8000_1000);
    check32("exc2_cause", cause_o, 32'h8000_0020);
    check32("exc2_badvaddr", rdata, 32'h13);

    eret = 1'b1;
    cycle();
    eret = 1'b0;
    check32("eret_status", status_o, 32'h0040_8001);

    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h200; exc_bd = 1'b0; exc_badvaddr = 32'h0;
    eret = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'h1;
    cycle();
    idle();
    check32("prio_status", status_o, 32'h0040_0003);
    check32("prio_epc", epc_o, 32'h200);
    check32("prio_cause", cause_o, 32'h0);

    // Reset mid-cycle with an exception and a write both pending.
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h44; exc_badvaddr = 32'h55;
    we = 1'b1; waddr = 5'd14; wdata = 32'hABCD;
    #2 rst = 1'b1;
    #1;
    check32("arst_status", status_o, 32'h0040_0000);
    check32("arst_epc", epc_o, 32'h0);
    cycle();
    idle();
    rst = 1'b0;
    cycle();
    check32("arst_epc2", epc_o, 32'h0);
    check32("arst_cause", cause_o, 32'h0);
    check32("arst_badvaddr", rdata, 32'h0);
    check32("arst_status2", status_o, 32'h0040_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
